// File: rtl/grab_channels_n.sv
// grab_channels_n: demultiplexes a burst-framed, interleaved I0,Q0,I1,Q1,...
// sample stream into N_CH I/Q pairs on a flat bus.
// A frame is collected in shadow registers and the whole output bus is
// committed on a single edge. Short bursts raise err_short, and over-long
// bursts (non-continuous mode only) raise err_long.
module grab_channels_n #(
    parameter int DW         = 16,
    parameter int N_CH       = 4,
    parameter int CONTINUOUS = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DW-1:0]        stream_in,
    input  logic                 strobe_in,
    output logic [2*N_CH*DW-1:0] iq_out,
    output logic                 strobe_out,
    output logic                 err_short,
    output logic                 err_long,
    output logic [15:0]          frame_cnt
);

    localparam int FL = 2 * N_CH;
    localparam int CW = ($clog2(FL) < 1) ? 1 : $clog2(FL);
    localparam logic [CW-1:0] LAST = CW'(FL - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE, DROP} state_t;

    state_t                  state_reg, state_next;
    logic [CW-1:0]           cnt_reg, cnt_next;
    logic                    store_en;
    logic                    commit;
    logic                    err_short_next;
    logic                    err_long_next;

    logic [(FL-1)*DW-1:0]    sh_flat;
    logic [2*N_CH*DW-1:0]    iq_reg;
    logic                    strobe_out_reg;
    logic                    err_short_reg;
    logic                    err_long_reg;
    logic [15:0]             frame_cnt_reg;

    // State and sample-counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic: decides where each strobed sample goes and which pulse fires
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        store_en       = 1'b0;
        commit         = 1'b0;
        err_short_next = 1'b0;
        err_long_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (strobe_in) begin
                    // cnt_reg is zero here, so this lands in sh[0]
                    store_en   = 1'b1;
                    cnt_next   = CW'(1);
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if (strobe_in) begin
                    if (cnt_reg == LAST) begin
                        commit     = 1'b1;
                        cnt_next   = '0;
                        state_next = (CONTINUOUS != 0) ? COLLECT : DONE;
                    end else begin
                        store_en = 1'b1;
                        cnt_next = cnt_reg + CW'(1);
                    end
                end else begin
                    // A drop exactly on a frame boundary (continuous mode) is clean
                    err_short_next = (cnt_reg != '0);
                    cnt_next       = '0;
                    state_next     = IDLE;
                end
            end
            DONE: begin
                cnt_next = '0;
                if (strobe_in) begin
                    err_long_next = 1'b1;
                    state_next    = DROP;
                end else begin
                    state_next = IDLE;
                end
            end
            DROP: begin
                cnt_next = '0;
                if (!strobe_in) begin
                    state_next = IDLE;
                end
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    // Shadow registers: one per sample slot except the last, which is taken live
    generate
        for (genvar gi = 0; gi < FL - 1; gi++) begin : g_sh
            logic [DW-1:0] sh_reg;

            // Capture the sample addressed by the counter
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sh_reg <= '0;
                end else if (store_en && (cnt_reg == CW'(gi))) begin
                    sh_reg <= stream_in;
                end
            end

            assign sh_flat[gi*DW +: DW] = sh_reg;
        end
    endgenerate

    // Atomic frame commit plus the one-cycle status pulses and frame counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iq_reg         <= '0;
            strobe_out_reg <= 1'b0;
            err_short_reg  <= 1'b0;
            err_long_reg   <= 1'b0;
            frame_cnt_reg  <= '0;
        end else begin
            strobe_out_reg <= commit;
            err_short_reg  <= err_short_next;
            err_long_reg   <= err_long_next;
            if (commit) begin
                iq_reg        <= {stream_in, sh_flat};
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
            end
        end
    end

    assign iq_out     = iq_reg;
    assign strobe_out = strobe_out_reg;
    assign err_short  = err_short_reg;
    assign err_long   = err_long_reg;
    assign frame_cnt  = frame_cnt_reg;

endmodule

// File: tb/tb_grab_channels_n.sv
// Scoreboard bench for grab_channels_n: four instances (N_CH=4 single-burst,
// N_CH=4 continuous, N_CH=1, N_CH=8). Stimulus pushes the expected pulse
// (kind, cycle, bus, frame count) into a per-instance queue; a monitor pops
// and compares whenever an instance raises strobe_out, err_short or err_long.
module tb_grab_channels_n;

    localparam int K_STB   = 0;
    localparam int K_SHORT = 1;
    localparam int K_LONG  = 2;

    typedef struct {
        int           kind;
        logic [255:0] iq;
        logic [15:0]  fc;
        longint       cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          st [4];
    logic [15:0]   din [4];
    logic [127:0]  iq0, iq1;
    logic [31:0]   iq2;
    logic [255:0]  iq3;
    logic          so [4];
    logic          es [4];
    logic          el [4];
    logic [15:0]   fc [4];

    longint        cyc = 0;
    int            n_checks = 0;
    int            n_fail = 0;
    exp_t          q [4][$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    grab_channels_n #(.DW(16), .N_CH(4), .CONTINUOUS(0)) u0 (
        .clk(clk), .rst(rst), .stream_in(din[0]), .strobe_in(st[0]),
        .iq_out(iq0), .strobe_out(so[0]), .err_short(es[0]), .err_long(el[0]),
        .frame_cnt(fc[0]));

    grab_channels_n #(.DW(16), .N_CH(4), .CONTINUOUS(1)) u1 (
        .clk(clk), .rst(rst), .stream_in(din[1]), .strobe_in(st[1]),
        .iq_out(iq1), .strobe_out(so[1]), .err_short(es[1]), .err_long(el[1]),
        .frame_cnt(fc[1]));

    grab_channels_n #(.DW(16), .N_CH(1), .CONTINUOUS(0)) u2 (
        .clk(clk), .rst(rst), .stream_in(din[2]), .strobe_in(st[2]),
        .iq_out(iq2), .strobe_out(so[2]), .err_short(es[2]), .err_long(el[2]),
        .frame_cnt(fc[2]));

    grab_channels_n #(.DW(16), .N_CH(8), .CONTINUOUS(0)) u3 (
        .clk(clk), .rst(rst), .stream_in(din[3]), .strobe_in(st[3]),
        .iq_out(iq3), .strobe_out(so[3]), .err_short(es[3]), .err_long(el[3]),
        .frame_cnt(fc[3]));

    function automatic logic [255:0] get_iq(input int d);
        logic [255:0] r;
        r = '0;
        case (d)
            0: r[127:0] = iq0;
            1: r[127:0] = iq1;
            2: r[31:0]  = iq2;
            default: r = iq3;
        endcase
        return r;
    endfunction

    // Expected bus for a frame of incrementing samples base, base+1, ...
    function automatic logic [255:0] exp_iq(input logic [15:0] base, input int fl);
        logic [255:0] r;
        r = '0;
        for (int j = 0; j < fl; j++) r[j*16 +: 16] = base + 16'(j);
        return r;
    endfunction

    task automatic push(input int d, input int kind, input logic [255:0] iq, input logic [15:0] f);
        exp_t e;
        e.kind = kind;
        e.iq   = iq;
        e.fc   = f;
        e.cyc  = cyc + 1;
        q[d].push_back(e);
    endtask

    task automatic drv(input int d, input bit s, input logic [15:0] v);
        st[d]  = s;
        din[d] = s ? v : 16'h0;
        @(posedge clk);
        #1;
    endtask

    task automatic burst(input int d, input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) drv(d, 1'b1, base + 16'(i));
    endtask

    task automatic check_zero(input int d, input string tag);
        n_checks++;
        if (get_iq(d) != '0 || fc[d] != 16'h0 || so[d] || es[d] || el[d]) begin
            n_fail++;
            $display("FAIL %s dut%0d: got iq=%h fc=%0d pulses=%b%b%b, need all zero",
                     tag, d, get_iq(d), fc[d], so[d], es[d], el[d]);
        end
    endtask

    task automatic check_dut(input int d);
        int   kind;
        exp_t e;
        if (!(so[d] || es[d] || el[d])) return;
        kind = so[d] ? K_STB : (es[d] ? K_SHORT : K_LONG);
        n_checks++;
        $display("dut%0d event kind=%0d fc=%0d cyc=%0d", d, kind, fc[d], cyc);
        if (int'(so[d]) + int'(es[d]) + int'(el[d]) > 1) begin
            n_fail++;
            $display("FAIL pulse_excl dut%0d: got so/es/el=%b%b%b, need one at a time",
                     d, so[d], es[d], el[d]);
        end else if (q[d].size() == 0) begin
            n_fail++;
            $display("FAIL unexpected dut%0d: got kind=%0d at cyc=%0d, need no event",
                     d, kind, cyc);
        end else begin
            e = q[d].pop_front();
            if (e.kind != kind || e.cyc != cyc || e.iq != get_iq(d) || e.fc != fc[d]) begin
                n_fail++;
                $display("FAIL event dut%0d: got kind=%0d cyc=%0d fc=%0d iq=%h, need kind=%0d cyc=%0d fc=%0d iq=%h",
                         d, kind, cyc, fc[d], get_iq(d), e.kind, e.cyc, e.fc, e.iq);
            end
        end
    endtask

    // Monitor: compare every presented pulse against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 4; d++) check_dut(d);
        end
    end

    initial begin
        for (int d = 0; d < 4; d++) begin
            st[d]  = 1'b0;
            din[d] = 16'h0;
        end
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) check_zero(d, "reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // u1: continuous, 24-sample burst -> three frames, clean drop on boundary
        burst(1, 16'd1, 7);
        push(1, K_STB, exp_iq(16'd1, 8), 16'd1);
        drv(1, 1'b1, 16'd8);
        burst(1, 16'd9, 7);
        push(1, K_STB, exp_iq(16'd9, 8), 16'd2);
        drv(1, 1'b1, 16'd16);
        burst(1, 16'd17, 7);
        push(1, K_STB, exp_iq(16'd17, 8), 16'd3);
        drv(1, 1'b1, 16'd24);
        drv(1, 1'b0, 16'h0);
        drv(1, 1'b0, 16'h0);
        // continuous mid-frame drop -> err_short, bus keeps 17..24
        burst(1, 16'h61, 3);
        push(1, K_SHORT, exp_iq(16'd17, 8), 16'd3);
        drv(1, 1'b0, 16'h0);
        drv(1, 1'b0, 16'h0);

        // u2: N_CH=1, FL=2
        drv(2, 1'b1, 16'hA1);
        push(2, K_STB, exp_iq(16'hA1, 2), 16'd1);
        drv(2, 1'b1, 16'hA2);
        drv(2, 1'b0, 16'h0);
        drv(2, 1'b1, 16'hB1);
        push(2, K_STB, exp_iq(16'hB1, 2), 16'd2);
        drv(2, 1'b1, 16'hB2);
        push(2, K_LONG, exp_iq(16'hB1, 2), 16'd2);
        drv(2, 1'b1, 16'hB3);
        drv(2, 1'b0, 16'h0);
        drv(2, 1'b1, 16'hC1);
        push(2, K_SHORT, exp_iq(16'hB1, 2), 16'd2);
        drv(2, 1'b0, 16'h0);
        drv(2, 1'b0, 16'h0);

        // u3: N_CH=8, full frame then a 15-sample short burst
        burst(3, 16'h100, 15);
        push(3, K_STB, exp_iq(16'h100, 16), 16'd1);
        drv(3, 1'b1, 16'h10F);
        drv(3, 1'b0, 16'h0);
        burst(3, 16'h200, 15);
        push(3, K_SHORT, exp_iq(16'h100, 16), 16'd1);
        drv(3, 1'b0, 16'h0);
        drv(3, 1'b0, 16'h0);

        // u0: basic 1..8 frame
        burst(0, 16'd1, 7);
        push(0, K_STB, exp_iq(16'd1, 8), 16'd1);
        drv(0, 1'b1, 16'd8);
        drv(0, 1'b0, 16'h0);
        drv(0, 1'b0, 16'h0);
        // u0: 5-sample short burst
        burst(0, 16'h10, 5);
        push(0, K_SHORT, exp_iq(16'd1, 8), 16'd1);
        drv(0, 1'b0, 16'h0);
        drv(0, 1'b0, 16'h0);
        // u0: 11-sample over-long burst, then a normal frame
        burst(0, 16'h21, 7);
        push(0, K_STB, exp_iq(16'h21, 8), 16'd2);
        drv(0, 1'b1, 16'h28);
        push(0, K_LONG, exp_iq(16'h21, 8), 16'd2);
        drv(0, 1'b1, 16'h29);
        drv(0, 1'b1, 16'h2A);
        drv(0, 1'b1, 16'h2B);
        drv(0, 1'b0, 16'h0);
        burst(0, 16'h31, 7);
        push(0, K_STB, exp_iq(16'h31, 8), 16'd3);
        drv(0, 1'b1, 16'h38);
        drv(0, 1'b0, 16'h0);
        drv(0, 1'b0, 16'h0);
        // u0: reset in the middle of a burst, then a clean frame
        burst(0, 16'h41, 4);
        rst   = 1'b1;
        st[0] = 1'b0;
        #1;
        check_zero(0, "midreset_assert");
        repeat (2) @(posedge clk);
        #1;
        check_zero(0, "midreset_hold");
        rst = 1'b0;
        drv(0, 1'b0, 16'h0);
        burst(0, 16'h51, 7);
        push(0, K_STB, exp_iq(16'h51, 8), 16'd1);
        drv(0, 1'b1, 16'h58);
        drv(0, 1'b0, 16'h0);

        repeat (4) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            n_checks++;
            if (q[d].size() != 0) begin
                n_fail++;
                $display("FAIL pending dut%0d: got %0d unseen events, need 0", d, q[d].size());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/grab_channels_n.md
Name: grab_channels_n

Overview:
- Parametrised successor to the fixed 4-channel I/Q grabber.
- Demultiplexes a burst-framed, interleaved I0,Q0,I1,Q1,… sample stream into N_CH I/Q pairs and presents them on a flat output bus.
- All outputs update atomically once per complete frame, so downstream never sees a mix of old and new channels.
- Detects short and over-long bursts, and supports an optional back-to-back (continuous) framing mode.
- Sits between the DDC/CIC decimator stream and the per-channel phase/magnitude processing.

Parameters:
- DW, 16, sample width in bits.
- N_CH, 4, number of I/Q channel pairs per frame (>=1); frame length FL = 2*N_CH samples.
- CONTINUOUS, 0, 0 = a frame is one strobe burst; 1 = consecutive frames allowed within one burst.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- stream_in  in  DW  interleaved sample data, valid when strobe_in=1.
- strobe_in  in  1  sample valid; a low cycle terminates a burst.
- iq_out  out  2*N_CH*DW  channel k occupies two slices: I_k at [(2k)*DW +: DW], Q_k at [(2k+1)*DW +: DW].
- strobe_out  out  1  one-cycle pulse; iq_out was just updated.
- err_short  out  1  one-cycle pulse; burst ended mid-frame.
- err_long  out  1  one-cycle pulse; burst exceeded FL (CONTINUOUS=0 only).
- frame_cnt  out  16  count of committed frames, wraps at 2^16.

Behaviour:
- Reset (async assert, sync-safe release): iq_out=0, strobe_out=0, err_short=0, err_long=0, frame_cnt=0, sample counter=0, state=IDLE, shadow regs=0.
- Sample counter cnt spans 0..FL-1, width $clog2(FL), minimum 1 bit.
- Shadow register array sh[0..FL-2] holds partial-frame samples.
- States:
  - IDLE: cnt=0. strobe_in=1 -> store sh[0]=stream_in, cnt=1, go COLLECT.
  - COLLECT, strobe_in=1 and cnt<FL-1: sh[cnt]=stream_in, cnt++.
  - COLLECT, strobe_in=1 and cnt==FL-1 (commit): iq_out = {stream_in, sh[FL-2..0]} in a single edge; strobe_out=1 next cycle; frame_cnt++; cnt=0.
    - After commit, CONTINUOUS=1 -> stay COLLECT, next strobed sample is I0 of a new frame.
    - After commit, CONTINUOUS=0 -> go DONE.
  - COLLECT, strobe_in=0: err_short=1 for one cycle; cnt=0; go IDLE; iq_out unchanged.
  - DONE (CONTINUOUS=0): strobe_in=1 -> err_long=1 for one cycle, go DROP; strobe_in=0 -> IDLE.
  - DROP: ignore all samples; strobe_in=0 -> IDLE. Only one err_long pulse per over-long burst.
- N_CH=1 with FL=2: commit on the second sample, same rules.
- CONTINUOUS=1 and strobe_in drops exactly on a frame boundary (cnt==0): no error, go IDLE.
- Latency: strobe_out and the new iq_out are visible in the cycle after the last sample is presented (1 clk). frame_cnt updates on the same edge.
- Shadow contents are not cleared on error; they are overwritten by the next frame, and iq_out never reflects them partially.
- Reset asserted mid-frame: frame discarded, no error pulse, all outputs return to reset values immediately.
- The three pulses (strobe_out, err_short, err_long) never exceed one cycle.
- strobe_out and err_short cannot both assert in the same cycle.
- No arithmetic on samples; data passes bit-exact.

Test Plan:
- N_CH=4, CONTINUOUS=0, 8-cycle burst of values 1..8 -> one cycle after the 8th sample: strobe_out=1, I0=1, Q0=2, I3=7, Q3=8, frame_cnt=1; err flags stay 0.
- Same configuration, 5-sample burst 0x10..0x14 -> err_short pulses once after strobe drops; iq_out keeps the prior frame; frame_cnt unchanged.
- Same configuration, 11-sample burst -> frame 1..8 committed; one err_long pulse on sample 9; samples 10 and 11 ignored; next 8-sample burst commits normally.
- CONTINUOUS=1, 24-sample burst -> three strobe_out pulses, 8 cycles apart; frame_cnt=3; iq_out holds samples 17..24.
- Assert rst at sample 4 of a burst, release, then send a clean 8-sample burst -> outputs all 0 during reset; the clean frame commits with no error pulse.
- N_CH=1 and N_CH=8 variants with an incrementing pattern -> correct slice mapping; frame_cnt wraps 0xFFFF->0 after 65536 frames (forced via a long CONTINUOUS run).
